// File: rtl/mmio_port_controller.sv
// -----------------------------------------------------------------------------
// mmio_port_controller
//
// Memory-mapped I/O port block for a single-cycle processor. It decodes a
// four-word register window at BASE_ADDR, holds a 32-bit output port register,
// and synchronizes an 8-bit asynchronous input port. It also flags input
// changes with sticky CHG/OVF status bits and counts them.
//
// Register map (word offset = Address[3:2]):
//   0 OUT    RW  32 bits, drives PortOut
//   1 IN     RO  8 bits zero-extended (synchronized PortIn); writes ignored
//   2 STATUS W1C bit0 CHG (input changed), bit1 OVF (change while CHG set)
//   3 COUNT  RW  8 bits zero-extended, +1 per detected input change (mod 256)
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  asynchronous active-low reset
//   MemWrite   in   1  store strobe
//   MemRead    in   1  load strobe
//   Address    in  32  processor byte address
//   WriteData  in  32  store data
//   ReadData   out 32  load data (combinational, 0 when not selected)
//   IO_Select  out  1  Address falls in the register window (combinational)
//   PortIn     in   8  asynchronous external input pins
//   PortOut    out 32  OUT register
//   InputEvent out  1  level copy of STATUS.CHG
// -----------------------------------------------------------------------------
module mmio_port_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IO_Select,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        InputEvent
);

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  // Architectural state
  logic [31:0] outReg_r;
  logic [7:0]  sync1_r;
  logic [7:0]  sync2_r;
  logic [7:0]  prev_r;
  logic        chg_r;
  logic        ovf_r;
  logic [7:0]  count_r;

  // Decode and next-state signals
  logic        ioSel_s;
  logic [1:0]  offset_s;
  logic        wrOut_s;
  logic        wrStatus_s;
  logic        wrCount_s;
  logic        chgPulse_s;
  logic [31:0] outNext_s;
  logic        chgNext_s;
  logic        ovfNext_s;
  logic [7:0]  countNext_s;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic        unusedAddrBits_s;
  assign unusedAddrBits_s = ^Address[1:0];

  // Address window decode and per-register write enables
  always_comb begin
    ioSel_s    = (Address[31:4] == BASE_ADDR[31:4]);
    offset_s   = Address[3:2];
    wrOut_s    = 1'b0;
    wrStatus_s = 1'b0;
    wrCount_s  = 1'b0;
    if (MemWrite && ioSel_s) begin
      case (offset_s)
        OFF_OUT:    wrOut_s    = 1'b1;
        OFF_IN:     wrOut_s    = 1'b0;  // IN is read-only; store is dropped
        OFF_STATUS: wrStatus_s = 1'b1;
        OFF_COUNT:  wrCount_s  = 1'b1;
        default:    wrOut_s    = 1'b0;
      endcase
    end else begin
      wrOut_s    = 1'b0;
    end
  end

  // One-cycle pulse whenever the synchronized input differs from last cycle
  assign chgPulse_s = (sync2_r != prev_r);

  // Next-state logic for OUT, STATUS and COUNT
  always_comb begin
    outNext_s   = outReg_r;
    chgNext_s   = chg_r;
    ovfNext_s   = ovf_r;
    countNext_s = count_r;

    if (wrOut_s) begin
      outNext_s = WriteData;
    end else begin
      outNext_s = outReg_r;
    end

    // Set has priority over a coincident write-one-to-clear so that an
    // input change arriving in the same cycle as software's clear is not lost.
    if (chgPulse_s) begin
      chgNext_s = 1'b1;
    end else if (wrStatus_s && WriteData[0]) begin
      chgNext_s = 1'b0;
    end else begin
      chgNext_s = chg_r;
    end

    // OVF uses the pre-edge CHG: a change seen while one is still pending.
    if (chgPulse_s && chg_r) begin
      ovfNext_s = 1'b1;
    end else if (wrStatus_s && WriteData[1]) begin
      ovfNext_s = 1'b0;
    end else begin
      ovfNext_s = ovf_r;
    end

    // A software load that coincides with a change still counts that change.
    if (wrCount_s) begin
      countNext_s = WriteData[7:0] + {7'd0, chgPulse_s};
    end else if (chgPulse_s) begin
      countNext_s = count_r + 8'd1;
    end else begin
      countNext_s = count_r;
    end
  end

  // Input synchronizer, previous-value flop and register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 8'h00;
      sync2_r  <= 8'h00;
      prev_r   <= 8'h00;
      outReg_r <= 32'h0000_0000;
      chg_r    <= 1'b0;
      ovf_r    <= 1'b0;
      count_r  <= 8'h00;
    end else begin
      sync1_r  <= PortIn;
      sync2_r  <= sync1_r;
      prev_r   <= sync2_r;
      outReg_r <= outNext_s;
      chg_r    <= chgNext_s;
      ovf_r    <= ovfNext_s;
      count_r  <= countNext_s;
    end
  end

  // Load data mux; reads never alter state
  always_comb begin
    ReadData = 32'h0000_0000;
    if (MemRead && ioSel_s) begin
      case (offset_s)
        OFF_OUT:    ReadData = outReg_r;
        OFF_IN:     ReadData = {24'h00_0000, sync2_r};
        OFF_STATUS: ReadData = {30'h0000_0000, ovf_r, chg_r};
        OFF_COUNT:  ReadData = {24'h00_0000, count_r};
        default:    ReadData = 32'h0000_0000;
      endcase
    end else begin
      ReadData = 32'h0000_0000;
    end
  end

  assign IO_Select  = ioSel_s;
  assign PortOut    = outReg_r;
  assign InputEvent = chg_r;

endmodule

// File: tb/tb_mmio_port_controller.sv
module tb_mmio_port_controller;

  localparam logic [31:0] BASE = 32'h1001_0020;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IO_Select;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        InputEvent;

  logic        chkStrobe;

  typedef struct {
    logic [31:0] rd;
    logic        sel;
    logic [31:0] pout;
    logic        iev;
    int          tag;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int errors = 0;

  mmio_port_controller #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .IO_Select  (IO_Select),
    .PortIn     (PortIn),
    .PortOut    (PortOut),
    .InputEvent (InputEvent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per presented observation, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chkStrobe) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: observation with no expectation");
        end else begin
          e = expQ.pop_front();
          if (ReadData !== e.rd) begin
            errors++;
            $display("FAIL readData[%0d] got %h exp %h", e.tag, ReadData, e.rd);
          end
          checks++;
          if (IO_Select !== e.sel) begin
            errors++;
            $display("FAIL ioSelect[%0d] got %b exp %b", e.tag, IO_Select, e.sel);
          end
          checks++;
          if (PortOut !== e.pout) begin
            errors++;
            $display("FAIL portOut[%0d] got %h exp %h", e.tag, PortOut, e.pout);
          end
          checks++;
          if (InputEvent !== e.iev) begin
            errors++;
            $display("FAIL inputEvent[%0d] got %b exp %b", e.tag, InputEvent, e.iev);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    Address   = addr;
    WriteData = data;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
  endtask

  // Present an observation cycle; optional simultaneous store
  task automatic probe(input logic rdEn, input logic wrEn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] expRd,
                       input logic expSel, input logic [31:0] expPout,
                       input logic expIev, input int tag);
    exp_t e;
    e.rd = expRd; e.sel = expSel; e.pout = expPout; e.iev = expIev; e.tag = tag;
    expQ.push_back(e);
    MemRead   = rdEn;
    MemWrite  = wrEn;
    Address   = addr;
    WriteData = wdata;
    chkStrobe = 1'b1;
    @(posedge clk); #1;
    chkStrobe = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] expRd, input logic expSel,
                      input logic [31:0] expPout, input logic expIev, input int tag);
    probe(1'b1, 1'b0, addr, 32'h0, expRd, expSel, expPout, expIev, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Address = 32'h0;
    WriteData = 32'h0; PortIn = 8'h00; chkStrobe = 1'b0;
    idle(2);

    // Reset state
    load(BASE + 32'd0,  32'h0, 1'b1, 32'h0, 1'b0, 1);
    load(BASE + 32'd8,  32'h0, 1'b1, 32'h0, 1'b0, 2);
    load(BASE + 32'd12, 32'h0, 1'b1, 32'h0, 1'b0, 3);
    reset = 1'b1;
    idle(1);

    // OUT store/load, byte offset ignored, MemRead low gives zero
    store(BASE, 32'hDEAD_BEEF);
    load(BASE, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 10);
    load(BASE + 32'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 11);
    probe(1'b0, 1'b0, BASE, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 12);

    // Input change latency: IN after N+1, CHG/COUNT at N+2
    PortIn = 8'h5A;
    idle(1);
    load(BASE + 32'd4, 32'h00, 1'b1, 32'hDEAD_BEEF, 1'b0, 20);
    load(BASE + 32'd4, 32'h5A, 1'b1, 32'hDEAD_BEEF, 1'b0, 21);
    load(BASE + 32'd8, 32'h1,  1'b1, 32'hDEAD_BEEF, 1'b1, 22);
    load(BASE + 32'd12, 32'h1, 1'b1, 32'hDEAD_BEEF, 1'b1, 23);

    // Second change without clear sets OVF; W1C both
    PortIn = 8'hA5;
    idle(3);
    load(BASE + 32'd8,  32'h3, 1'b1, 32'hDEAD_BEEF, 1'b1, 30);
    load(BASE + 32'd12, 32'h2, 1'b1, 32'hDEAD_BEEF, 1'b1, 31);
    store(BASE + 32'd8, 32'h3);
    load(BASE + 32'd8,  32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32);
    load(BASE + 32'd12, 32'h2, 1'b1, 32'hDEAD_BEEF, 1'b0, 33);

    // Clear of CHG coincident with a new change: set wins
    PortIn = 8'h11;
    idle(3);
    load(BASE + 32'd8, 32'h1, 1'b1, 32'hDEAD_BEEF, 1'b1, 40);
    PortIn = 8'h22;
    idle(2);
    store(BASE + 32'd8, 32'h1);
    load(BASE + 32'd8,  32'h3, 1'b1, 32'hDEAD_BEEF, 1'b1, 41);
    load(BASE + 32'd12, 32'h4, 1'b1, 32'hDEAD_BEEF, 1'b1, 42);
    store(BASE + 32'd8, 32'h3);
    load(BASE + 32'd8,  32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 43);

    // COUNT wrap and write coincident with a change
    store(BASE + 32'd12, 32'hFFFF_FFFF);
    load(BASE + 32'd12, 32'hFF, 1'b1, 32'hDEAD_BEEF, 1'b0, 50);
    PortIn = 8'h33;
    idle(3);
    load(BASE + 32'd12, 32'h00, 1'b1, 32'hDEAD_BEEF, 1'b1, 51);
    load(BASE + 32'd8,  32'h1,  1'b1, 32'hDEAD_BEEF, 1'b1, 52);
    PortIn = 8'h44;
    idle(2);
    store(BASE + 32'd12, 32'h10);
    load(BASE + 32'd12, 32'h11, 1'b1, 32'hDEAD_BEEF, 1'b1, 53);
    load(BASE + 32'd8,  32'h3,  1'b1, 32'hDEAD_BEEF, 1'b1, 54);

    // IN is read-only
    store(BASE + 32'd4, 32'h0000_00FF);
    load(BASE + 32'd4, 32'h44, 1'b1, 32'hDEAD_BEEF, 1'b1, 60);

    // Simultaneous load/store: read shows pre-edge value
    probe(1'b1, 1'b1, BASE, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 70);
    load(BASE, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 71);

    // Out-of-window accesses
    store(BASE + 32'd16, 32'hFFFF_FFFF);
    store(32'h0000_0040, 32'hFFFF_FFFF);
    load(BASE + 32'd16, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 80);
    load(32'h0000_0040, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 81);
    load(BASE, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 82);
    load(BASE + 32'd12, 32'h11, 1'b1, 32'h1234_5678, 1'b1, 83);
    load(BASE + 32'd8,  32'h3,  1'b1, 32'h1234_5678, 1'b1, 84);

    // Reset mid-detection, then exactly one change from the held input
    PortIn = 8'h99;
    idle(1);
    reset = 1'b0;
    #1;
    load(BASE + 32'd8,  32'h0, 1'b1, 32'h0, 1'b0, 90);
    load(BASE,          32'h0, 1'b1, 32'h0, 1'b0, 91);
    load(BASE + 32'd12, 32'h0, 1'b1, 32'h0, 1'b0, 92);
    reset = 1'b1;
    idle(3);
    load(BASE + 32'd12, 32'h1,  1'b1, 32'h0, 1'b1, 93);
    load(BASE + 32'd8,  32'h1,  1'b1, 32'h0, 1'b1, 94);
    idle(3);
    load(BASE + 32'd12, 32'h1,  1'b1, 32'h0, 1'b1, 95);
    load(BASE + 32'd4,  32'h99, 1'b1, 32'h0, 1'b1, 96);

    idle(2);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending exp 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_port_controller.md
MMIO_PORT_CONTROLLER -- requirements
Module: mmio_port_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0020, byte address of register 0; aligned to 16 bytes.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port MemWrite  input  1  processor store strobe, valid for one cycle per store.
REQ-005 SHALL have port MemRead  input  1  processor load strobe.
REQ-006 SHALL have port Address  input  32  processor byte address (ALU result of load/store).
REQ-007 SHALL have port WriteData  input  32  store data.
REQ-008 SHALL have port ReadData  output  32  load data returned to processor.
REQ-009 SHALL have port IO_Select  output  1  high when Address hits the register window; the processor uses it to steer its load mux away from data RAM.
REQ-010 SHALL have port PortIn  input  8  asynchronous external input pins.
REQ-011 SHALL have port PortOut  output  32  registered output port.
REQ-012 SHALL have port InputEvent  output  1  level copy of STATUS.CHG.

Function
REQ-013 IO_Select SHALL be combinational: 1 iff Address[31:4] == BASE_ADDR[31:4]; Address[1:0] ignored; offset = Address[3:2].
REQ-014 Register map SHALL be: off 0 OUT (RW, 32b); off 1 IN (RO, 8b zero-extended); off 2 STATUS (bit0 CHG, bit1 OVF, W1C); off 3 COUNT (RW, 8b zero-extended).
REQ-015 Writes SHALL take effect on the rising edge when MemWrite=1 and IO_Select=1; writes without IO_Select SHALL be ignored.
REQ-016 ReadData SHALL be combinational: selected register value when MemRead=1 and IO_Select=1, else 32'h0.
REQ-017 PortIn SHALL pass through a 2-flop synchronizer (sync1, sync2); IN register = sync2; a third flop prev holds the prior sync2.
REQ-018 Change detect SHALL be: chg_pulse = (sync2 != prev), one cycle wide.
REQ-019 Latency SHALL be: a PortIn change stable before edge N is visible in IN after edge N+1; CHG sets and COUNT increments at edge N+2.
REQ-020 CHG SHALL be sticky: set on chg_pulse; cleared by a STATUS write with WriteData[0]=1.
REQ-021 OVF SHALL set when chg_pulse occurs while CHG is already 1; cleared by a STATUS write with WriteData[1]=1.
REQ-022 Same-cycle clear and set SHALL resolve with set winning: CHG/OVF stay 1.
REQ-023 COUNT SHALL increment by 1 per chg_pulse, modulo 256 (8'hFF + 1 -> 8'h00, no flag).
REQ-024 A COUNT write SHALL load WriteData[7:0]; write plus chg_pulse in the same cycle SHALL load WriteData[7:0] + 1.
REQ-025 OUT write SHALL load all 32 bits; PortOut = OUT register, updated the edge after the store.
REQ-026 Writes to offset 1 (IN) SHALL have no effect.
REQ-027 MemRead and MemWrite both high SHALL perform the write; ReadData shows the pre-edge value.
REQ-028 Reads SHALL have no side effects (no clear-on-read).

Reset
REQ-029 While reset=0, asynchronously: OUT=0, PortOut=0, sync1=sync2=prev=0, CHG=0, OVF=0, COUNT=0, InputEvent=0.
REQ-030 Reset asserted mid-operation SHALL abort pending detection; after release, a PortIn value already nonzero SHALL produce exactly one chg_pulse (0 -> value transition through the synchronizer).
REQ-031 The first rising edge after reset release SHALL be a normal operating edge.

Verification
REQ-032 Store 32'hDEAD_BEEF to BASE+0 -> PortOut=32'hDEAD_BEEF the next cycle; load BASE+0 returns the same value; IO_Select=1.
REQ-033 PortIn 8'h00 -> 8'h5A at edge N -> IN reads 8'h5A after N+1; CHG=1, InputEvent=1, COUNT=1 at N+2; OVF=0.
REQ-034 Two PortIn changes with no clear in between -> CHG=1, OVF=1, COUNT=2; store 32'h3 to BASE+8 -> STATUS reads 0.
REQ-035 W1C of CHG in the same cycle as a new chg_pulse -> CHG stays 1; COUNT increments.
REQ-036 Store 8'hFF to BASE+12, then one change -> COUNT=8'h00; store 8'h10 coincident with chg_pulse -> COUNT=8'h11.
REQ-037 Load/store at BASE+16 and at 32'h0000_0040 -> IO_Select=0, ReadData=0, no register changes; assert reset mid-sequence -> all outputs 0 immediately.
